// File: rtl/tug_of_war_ctrl.sv
// Tug-of-war game sequencer: ready countdown, play, win flash, done and foul handling.
// Drives the LED mux select, one-hot rope position and winner flags from two debounced buttons.
module tug_of_war_ctrl #(
   parameter int TICK_DIV    = 12_500_000,
   parameter int READY_TICKS = 8,
   parameter int FLASH_TICKS = 2,
   parameter int WIN_FLASHES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_l,
   input  logic       btn_r,
   output logic [1:0] leds_ctrl,
   output logic [6:0] score,
   output logic [1:0] winner,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      S_READY = 3'd0,
      S_PLAY  = 3'd1,
      S_WIN   = 3'd2,
      S_DONE  = 3'd3,
      S_FOUL  = 3'd4
   } state_t;

   localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int TCNT_MAX = (READY_TICKS > FLASH_TICKS) ? READY_TICKS : FLASH_TICKS;
   localparam int TCNT_W   = $clog2(TCNT_MAX + 1);
   localparam int FL_W     = $clog2(WIN_FLASHES + 1);

   localparam logic [DIV_W-1:0]  TICK_LAST  = DIV_W'(TICK_DIV - 1);
   localparam logic [TCNT_W-1:0] READY_LAST = TCNT_W'(READY_TICKS - 1);
   localparam logic [TCNT_W-1:0] FLASH_LAST = TCNT_W'(FLASH_TICKS - 1);
   localparam logic [FL_W-1:0]   FLIP_LAST  = FL_W'(WIN_FLASHES - 1);

   localparam logic [6:0] SCORE_MID = 7'b0001000;
   localparam logic [6:0] SCORE_L   = 7'b1000000;
   localparam logic [6:0] SCORE_R   = 7'b0000001;

   localparam logic [1:0] LEDS_OFF   = 2'd0;
   localparam logic [1:0] LEDS_ON    = 2'd1;
   localparam logic [1:0] LEDS_CODE  = 2'd2;
   localparam logic [1:0] LEDS_SCORE = 2'd3;

   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_LEFT  = 2'b10;
   localparam logic [1:0] WIN_RIGHT = 2'b01;

   // Held as plain bits so an out-of-range encoding stays representable and recoverable.
   logic [2:0]        state_q;
   state_t            state_nxt;

   logic              btn_l_q, btn_r_q;
   logic              press_l, press_r;
   logic              tick;

   logic [DIV_W-1:0]  tick_cnt, tick_cnt_nxt;
   logic [TCNT_W-1:0] tcnt, tcnt_nxt;
   logic [FL_W-1:0]   flip_cnt, flip_cnt_nxt;
   logic [1:0]        leds_nxt;
   logic [6:0]        score_nxt, shifted;
   logic [1:0]        winner_nxt;

   assign press_l   = btn_l & ~btn_l_q;
   assign press_r   = btn_r & ~btn_r_q;
   assign tick      = (tick_cnt == TICK_LAST);
   assign state_dbg = state_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_READY;
         btn_l_q   <= 1'b0;
         btn_r_q   <= 1'b0;
         tick_cnt  <= '0;
         tcnt      <= '0;
         flip_cnt  <= '0;
         leds_ctrl <= LEDS_OFF;
         score     <= SCORE_MID;
         winner    <= WIN_NONE;
      end else begin
         state_q   <= state_nxt;
         btn_l_q   <= btn_l;
         btn_r_q   <= btn_r;
         tick_cnt  <= tick_cnt_nxt;
         tcnt      <= tcnt_nxt;
         flip_cnt  <= flip_cnt_nxt;
         leds_ctrl <= leds_nxt;
         score     <= score_nxt;
         winner    <= winner_nxt;
      end
   end

   // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_nxt    = state_t'(state_q);
      tick_cnt_nxt = tick ? '0 : tick_cnt + DIV_W'(1);
      tcnt_nxt     = tcnt;
      flip_cnt_nxt = flip_cnt;
      leds_nxt     = leds_ctrl;
      score_nxt    = score;
      winner_nxt   = winner;
      shifted      = score;

      case (state_q)
         S_READY: begin
            leds_nxt = LEDS_OFF;
            if (press_l || press_r) begin
               state_nxt = S_FOUL;
               leds_nxt  = LEDS_CODE;
               // Jumping the gun hands the round to the other player.
               if (press_l && press_r) winner_nxt = WIN_NONE;
               else if (press_l)       winner_nxt = WIN_RIGHT;
               else                    winner_nxt = WIN_LEFT;
            end else if (tick) begin
               if (tcnt == READY_LAST) begin
                  state_nxt = S_PLAY;
                  leds_nxt  = LEDS_SCORE;
                  score_nxt = SCORE_MID;
               end else begin
                  tcnt_nxt = tcnt + TCNT_W'(1);
               end
            end
         end

         S_PLAY: begin
            leds_nxt = LEDS_SCORE;
            if (press_l && !press_r)      shifted = score << 1;
            else if (press_r && !press_l) shifted = score >> 1;
            score_nxt = shifted;
            if (shifted == SCORE_L) begin
               state_nxt  = S_WIN;
               winner_nxt = WIN_LEFT;
               leds_nxt   = LEDS_ON;
            end else if (shifted == SCORE_R) begin
               state_nxt  = S_WIN;
               winner_nxt = WIN_RIGHT;
               leds_nxt   = LEDS_ON;
            end
         end

         S_WIN: begin
            if (tick) begin
               if (tcnt == FLASH_LAST) begin
                  tcnt_nxt = '0;
                  if (flip_cnt == FLIP_LAST) begin
                     state_nxt = S_DONE;
                     leds_nxt  = LEDS_SCORE;
                  end else begin
                     flip_cnt_nxt = flip_cnt + FL_W'(1);
                     leds_nxt     = (leds_ctrl == LEDS_ON) ? LEDS_SCORE : LEDS_ON;
                  end
               end else begin
                  tcnt_nxt = tcnt + TCNT_W'(1);
               end
            end
         end

         S_DONE, S_FOUL: begin
            // Both buttons held together is the only way back to a fresh round.
            if (btn_l && btn_r) begin
               state_nxt  = S_READY;
               leds_nxt   = LEDS_OFF;
               score_nxt  = SCORE_MID;
               winner_nxt = WIN_NONE;
            end
         end

         default: begin
            state_nxt  = S_READY;
            leds_nxt   = LEDS_OFF;
            score_nxt  = SCORE_MID;
            winner_nxt = WIN_NONE;
         end
      endcase

      // Every state starts with a full tick period and fresh tick/flash counts.
      if (state_nxt != state_q) begin
         tick_cnt_nxt = '0;
         tcnt_nxt     = '0;
         flip_cnt_nxt = '0;
      end
   end

endmodule
